// File: rtl/c2h_rr_sched.sv
// Packet-level round-robin scheduler for the shared QDMA C2H stream port.
// Grants one whole fixed-length packet per source, steers its beats to the
// C2H port, and queues a completion request for every finished packet.
module c2h_rr_sched #(
    parameter int unsigned NUM_SRC       = 4,
    parameter int unsigned DATA_WIDTH    = 256,
    parameter int unsigned PKT_WORDS_LEN = 8,
    parameter int unsigned QID_WIDTH     = 11,
    parameter int unsigned CMPT_DEPTH    = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cfg_en,
    input  logic [QID_WIDTH-1:0]          cfg_qid_base,
    input  logic [NUM_SRC-1:0]            s_tvalid,
    output logic [NUM_SRC-1:0]            s_tready,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] s_tdata,
    output logic                          m_tvalid,
    input  logic                          m_tready,
    output logic [DATA_WIDTH-1:0]         m_tdata,
    output logic                          m_tlast,
    output logic [QID_WIDTH-1:0]          m_ctrl_qid,
    output logic [15:0]                   m_ctrl_len,
    output logic                          cmpt_tvalid,
    input  logic                          cmpt_tready,
    output logic [QID_WIDTH-1:0]          cmpt_qid,
    output logic [15:0]                   cmpt_pkt_id,
    output logic                          busy,
    output logic [$clog2(NUM_SRC)-1:0]    grant_idx
);

    localparam int unsigned IDX_W = $clog2(NUM_SRC);
    localparam int unsigned CNT_W = (PKT_WORDS_LEN > 1) ? $clog2(PKT_WORDS_LEN) : 1;
    localparam int unsigned PTR_W = (CMPT_DEPTH > 1) ? $clog2(CMPT_DEPTH) : 1;
    localparam int unsigned ENT_W = QID_WIDTH + 16;

    localparam logic [15:0]      CtrlLen   = 16'(PKT_WORDS_LEN * DATA_WIDTH / 8);
    localparam logic [CNT_W-1:0] LastBeat  = CNT_W'(PKT_WORDS_LEN - 1);
    localparam logic [IDX_W-1:0] LastSrc   = IDX_W'(NUM_SRC - 1);
    localparam logic [PTR_W-1:0] LastSlot  = PTR_W'(CMPT_DEPTH - 1);
    localparam logic [PTR_W:0]   DepthCnt  = (PTR_W + 1)'(CMPT_DEPTH);

    typedef enum logic {StIdle, StXfer} state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     rr_ptr_q;
    logic [IDX_W-1:0]     grant_q;
    logic [QID_WIDTH-1:0] qid_q;
    logic [CNT_W-1:0]     beat_q;
    logic [15:0]          pkt_id_q [NUM_SRC];

    logic [ENT_W-1:0]     cmpt_mem [CMPT_DEPTH];
    logic [PTR_W-1:0]     cmpt_wr_q, cmpt_rd_q;
    logic [PTR_W:0]       cmpt_cnt_q;
    logic [ENT_W-1:0]     cmpt_head;

    logic                 win_found;
    logic [IDX_W-1:0]     win_idx;
    logic                 grant_ok, grant_take, beat_hs, last_hs, push, pop;

    // Round-robin search: first requesting source at or after rr_ptr, with wrap.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!win_found && s_tvalid[(int'(rr_ptr_q) + i) % NUM_SRC]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'((int'(rr_ptr_q) + i) % NUM_SRC);
            end
        end
    end

    // The in-flight packet holds the only reservation, so in IDLE the occupancy
    // alone decides whether a completion slot is still free.
    assign grant_ok = cfg_en && win_found && (cmpt_cnt_q < DepthCnt);

    // Next state and C2H steering.
    always_comb begin
        state_d    = state_q;
        grant_take = 1'b0;
        beat_hs    = 1'b0;
        last_hs    = 1'b0;
        m_tvalid   = 1'b0;
        m_tdata    = '0;
        m_tlast    = 1'b0;
        m_ctrl_qid = '0;
        s_tready   = '0;
        unique case (state_q)
            StIdle: begin
                if (grant_ok) begin
                    state_d    = StXfer;
                    grant_take = 1'b1;
                end
            end
            StXfer: begin
                m_tvalid          = s_tvalid[grant_q];
                m_tdata           = s_tdata[grant_q*DATA_WIDTH +: DATA_WIDTH];
                s_tready[grant_q] = m_tready;
                m_tlast           = (beat_q == LastBeat);
                m_ctrl_qid        = qid_q;
                beat_hs           = m_tvalid && m_tready;
                last_hs           = beat_hs && m_tlast;
                if (last_hs) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM state, grant latch and beat counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            qid_q    <= '0;
            beat_q   <= '0;
        end else begin
            state_q <= state_d;
            if (grant_take) begin
                grant_q  <= win_idx;
                qid_q    <= cfg_qid_base + QID_WIDTH'(win_idx);
                rr_ptr_q <= (win_idx == LastSrc) ? '0 : win_idx + 1'b1;
            end
            if (last_hs) beat_q <= '0;
            else if (beat_hs) beat_q <= beat_q + 1'b1;
        end
    end

    // Per-source packet numbers start at 1 and wrap through 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_SRC; i++) pkt_id_q[i] <= 16'd1;
        end else if (last_hs) begin
            pkt_id_q[grant_q] <= pkt_id_q[grant_q] + 16'd1;
        end
    end

    assign push = last_hs;
    assign pop  = cmpt_tvalid && cmpt_tready;

    // Completion FIFO storage; contents are only visible while non-empty.
    always_ff @(posedge clk) begin
        if (push) cmpt_mem[cmpt_wr_q] <= {qid_q, pkt_id_q[grant_q]};
    end

    // Completion FIFO pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmpt_wr_q  <= '0;
            cmpt_rd_q  <= '0;
            cmpt_cnt_q <= '0;
        end else begin
            if (push) cmpt_wr_q <= (cmpt_wr_q == LastSlot) ? '0 : cmpt_wr_q + 1'b1;
            if (pop)  cmpt_rd_q <= (cmpt_rd_q == LastSlot) ? '0 : cmpt_rd_q + 1'b1;
            if (push && !pop) cmpt_cnt_q <= cmpt_cnt_q + 1'b1;
            else if (!push && pop) cmpt_cnt_q <= cmpt_cnt_q - 1'b1;
        end
    end

    assign cmpt_head   = cmpt_mem[cmpt_rd_q];
    assign cmpt_tvalid = (cmpt_cnt_q != '0);
    assign cmpt_qid    = cmpt_tvalid ? cmpt_head[ENT_W-1:16] : '0;
    assign cmpt_pkt_id = cmpt_tvalid ? cmpt_head[15:0] : '0;

    assign m_ctrl_len = CtrlLen;
    assign busy       = (state_q == StXfer);
    assign grant_idx  = grant_q;

    cmpt_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && (cmpt_cnt_q == DepthCnt)));

endmodule

// File: tb/tb_c2h_rr_sched.sv
// Self-checking bench for c2h_rr_sched: directed scenarios plus random traffic,
// compared every cycle against a transaction-level reference model.
module tb_c2h_rr_sched;

    localparam int NS = 4;
    localparam int DW = 256;
    localparam int PW = 8;
    localparam int QW = 11;
    localparam int CD = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            cfg_en = 1'b0;
    logic [QW-1:0]   cfg_qid_base = '0;
    logic [NS-1:0]   s_tvalid = '0;
    logic [NS-1:0]   s_tready;
    logic [NS*DW-1:0] s_tdata = '0;
    logic            m_tvalid;
    logic            m_tready = 1'b0;
    logic [DW-1:0]   m_tdata;
    logic            m_tlast;
    logic [QW-1:0]   m_ctrl_qid;
    logic [15:0]     m_ctrl_len;
    logic            cmpt_tvalid;
    logic            cmpt_tready = 1'b0;
    logic [QW-1:0]   cmpt_qid;
    logic [15:0]     cmpt_pkt_id;
    logic            busy;
    logic [1:0]      grant_idx;

    c2h_rr_sched #(
        .NUM_SRC(NS), .DATA_WIDTH(DW), .PKT_WORDS_LEN(PW), .QID_WIDTH(QW), .CMPT_DEPTH(CD)
    ) dut (
        .clk(clk), .rst(rst), .cfg_en(cfg_en), .cfg_qid_base(cfg_qid_base),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tlast(m_tlast),
        .m_ctrl_qid(m_ctrl_qid), .m_ctrl_len(m_ctrl_len),
        .cmpt_tvalid(cmpt_tvalid), .cmpt_tready(cmpt_tready), .cmpt_qid(cmpt_qid),
        .cmpt_pkt_id(cmpt_pkt_id), .busy(busy), .grant_idx(grant_idx)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Each source emits a numbered beat stream so steering and order are visible.
    function automatic logic [DW-1:0] beat_data(input int s, input int b);
        return DW'({8'(s), 24'(b)});
    endfunction

    typedef struct packed {
        logic [QW-1:0] qid;
        logic [15:0]   id;
    } ent_t;

    // Reference model state (transaction level).
    int            src_beat [NS];
    bit            mb;
    int            msrc, mbeats, mptr, grants;
    logic [QW-1:0] mqid;
    logic [15:0]   mpid [NS];
    ent_t          mq [$];

    task automatic model_reset();
        mb = 0; msrc = 0; mbeats = 0; mptr = 0;
        mqid = '0;
        for (int i = 0; i < NS; i++) mpid[i] = 16'd1;
        mq.delete();
    endtask

    initial begin
        for (int i = 0; i < NS; i++) src_beat[i] = 0;
        grants = 0;
        model_reset();
    end

    // Monitor: compare outputs mid-cycle, then advance the model past the next edge.
    initial begin
        int  occ;
        bit  found;
        forever begin
            @(negedge clk);
            if (rst) begin
                model_reset();
                check("rst_busy", busy, 0);
                check("rst_mvalid", m_tvalid, 0);
                check("rst_sready", s_tready, 0);
                check("rst_cvalid", cmpt_tvalid, 0);
                check("rst_qid", m_ctrl_qid, 0);
            end else begin
                check("busy", busy, mb);
                if (mb) begin
                    check("m_tvalid", m_tvalid, s_tvalid[msrc]);
                    check("s_tready", s_tready, NS'(m_tready) << msrc);
                    check("m_tlast", m_tlast, mbeats == PW - 1);
                    check("ctrl_qid", m_ctrl_qid, mqid);
                    check("grant_idx", grant_idx, msrc);
                    if (m_tvalid) check("m_tdata", m_tdata, beat_data(msrc, src_beat[msrc]));
                end else begin
                    check("idle_mvalid", m_tvalid, 0);
                    check("idle_sready", s_tready, 0);
                    check("idle_tlast", m_tlast, 0);
                end
                check("cmpt_tvalid", cmpt_tvalid, mq.size() != 0);
                if (mq.size() != 0) begin
                    check("cmpt_qid", cmpt_qid, mq[0].qid);
                    check("cmpt_pkt_id", cmpt_pkt_id, mq[0].id);
                end
                occ = mq.size();
                if (occ != 0 && cmpt_tready) void'(mq.pop_front());
                if (mb) begin
                    if (s_tvalid[msrc] && m_tready) begin
                        src_beat[msrc]++;
                        mbeats++;
                        if (mbeats == PW) begin
                            mq.push_back('{mqid, mpid[msrc]});
                            mpid[msrc] = mpid[msrc] + 16'd1;
                            mb = 0;
                            mbeats = 0;
                        end
                    end
                end else if (cfg_en && s_tvalid != 0 && occ < CD) begin
                    found = 0;
                    for (int k = 0; k < NS; k++) begin
                        if (!found && s_tvalid[(mptr + k) % NS]) begin
                            found = 1;
                            msrc = (mptr + k) % NS;
                        end
                    end
                    mb = 1;
                    mqid = cfg_qid_base + QW'(msrc);
                    mptr = (msrc + 1) % NS;
                    grants++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < NS; i++) s_tdata[i*DW +: DW] = beat_data(i, src_beat[i]);
    endtask

    // Finish the in-flight packet with only its own source requesting.
    task automatic drain();
        m_tready = 1'b1;
        for (int k = 0; k < 40 && busy; k++) begin
            s_tvalid = NS'(1) << grant_idx;
            tick();
        end
        s_tvalid = '0;
        check("drain_idle", busy, 0);
    endtask

    initial begin
        int g0;
        tick(); tick(); tick();
        rst = 1'b0;
        check("ctrl_len", m_ctrl_len, 16'(PW * DW / 8));
        check("rst_grant_idx", grant_idx, 0);

        // Single source: src2 with base 0x010.
        cfg_en = 1'b1; cfg_qid_base = 11'h010; s_tvalid = 4'b0100;
        m_tready = 1'b1; cmpt_tready = 1'b0;
        for (int k = 0; k < 40 && !cmpt_tvalid; k++) tick();
        check("p1_cvalid", cmpt_tvalid, 1);
        check("p1_cqid", cmpt_qid, 11'h012);
        check("p1_cid", cmpt_pkt_id, 1);
        cmpt_tready = 1'b1; tick(); cmpt_tready = 1'b0;
        for (int k = 0; k < 40 && !cmpt_tvalid; k++) tick();
        s_tvalid = '0;
        check("p2_cid", cmpt_pkt_id, 2);
        drain();
        cmpt_tready = 1'b1; tick(); tick(); tick();

        // Fairness: all sources requesting continuously.
        g0 = grants; s_tvalid = '1;
        for (int k = 0; k < 120 && grants - g0 < 8; k++) tick();
        check("fair_pkts", grants - g0, 8);
        drain();
        tick(); tick(); tick();

        // Backpressure: ready toggles, src1 valid drops for three cycles.
        g0 = grants;
        for (int c = 0; c < 40; c++) begin
            m_tready = c[0];
            s_tvalid = (c >= 6 && c < 9) ? 4'b0000 : 4'b0010;
            tick();
            if (g0 == grants && busy == 0 && c > 30) break;
        end
        drain();

        // Completion FIFO full: four packets then stall, one pop frees one grant.
        cmpt_tready = 1'b1; tick(); tick(); tick(); tick(); tick();
        cmpt_tready = 1'b0; g0 = grants; s_tvalid = '1; m_tready = 1'b1;
        for (int k = 0; k < 60; k++) tick();
        check("full_pkts", grants - g0, 4);
        check("full_stall", busy, 0);
        cmpt_tready = 1'b1; tick(); cmpt_tready = 1'b0;
        for (int k = 0; k < 30; k++) tick();
        check("full_one_more", grants - g0, 5);
        drain();
        cmpt_tready = 1'b1; tick(); tick(); tick(); tick(); tick();

        // Enable dropped mid-packet: packet completes, no further grant.
        cmpt_tready = 1'b0; g0 = grants; s_tvalid = 4'b0001;
        for (int k = 0; k < 20 && !busy; k++) tick();
        tick(); tick(); tick();
        cfg_en = 1'b0;
        for (int k = 0; k < 20; k++) tick();
        check("en_off_idle", busy, 0);
        check("en_off_pkts", grants - g0, 1);

        // Queue ID arithmetic and wrap.
        cfg_en = 1'b1; cfg_qid_base = 11'h7FE; s_tvalid = 4'b0010;
        for (int k = 0; k < 20 && !busy; k++) tick();
        check("qid_7ff", m_ctrl_qid, 11'h7FF);
        drain();
        cfg_qid_base = 11'h7FF; s_tvalid = 4'b0010;
        for (int k = 0; k < 20 && !busy; k++) tick();
        check("qid_wrap", m_ctrl_qid, 11'h000);
        drain();

        // Reset mid-packet while completions are pending.
        cfg_qid_base = 11'h020; s_tvalid = 4'b0001;
        for (int k = 0; k < 20 && !busy; k++) tick();
        tick(); tick(); tick(); tick();
        check("pre_rst_cvalid", cmpt_tvalid, 1);
        rst = 1'b1;
        #1;
        check("async_busy", busy, 0);
        check("async_mvalid", m_tvalid, 0);
        check("async_cvalid", cmpt_tvalid, 0);
        tick();
        rst = 1'b0;
        for (int k = 0; k < 40 && !cmpt_tvalid; k++) tick();
        check("post_rst_cqid", cmpt_qid, 11'h020);
        check("post_rst_cid", cmpt_pkt_id, 1);
        drain();

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            s_tvalid    = NS'($urandom);
            m_tready    = ($urandom % 4) != 0;
            cmpt_tready = ($urandom % 3) == 0;
            cfg_en      = ($urandom % 16) != 0;
            if ($urandom % 200 == 0) cfg_qid_base = QW'($urandom);
            tick();
        end
        cfg_en = 1'b1;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/c2h_rr_sched.md
Name: c2h_rr_sched

Overview:
- Packet-level round-robin scheduler sharing the single QDMA C2H streaming port among NUM_SRC fixed-length packet sources. Each source maps to its own queue ID.
- Grants the port one whole packet at a time, steers the data, and generates tlast, ctrl_qid and ctrl_len.
- Queues one completion request per finished packet for the C2H CMPT sideband logic.

Parameters:
- NUM_SRC, 4, number of requesting sources (2..8)
- DATA_WIDTH, 256, beat width in bits
- PKT_WORDS_LEN, 8, beats per packet (>=1)
- QID_WIDTH, 11, queue ID width
- CMPT_DEPTH, 4, completion request FIFO depth (power of 2)

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- cfg_en  in  1  scheduler enable
- cfg_qid_base  in  QID_WIDTH  queue ID of source 0; source i uses base+i, modulo 2^QID_WIDTH
- s_tvalid  in  NUM_SRC  per-source valid
- s_tready  out  NUM_SRC  per-source ready
- s_tdata  in  NUM_SRC*DATA_WIDTH  source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- m_tvalid  out  1  C2H valid
- m_tready  in  1  C2H ready
- m_tdata  out  DATA_WIDTH  C2H data
- m_tlast  out  1  last beat of the packet
- m_ctrl_qid  out  QID_WIDTH  queue ID of the current packet
- m_ctrl_len  out  16  PKT_WORDS_LEN*DATA_WIDTH/8, constant
- cmpt_tvalid  out  1  completion request valid
- cmpt_tready  in  1  completion request accepted
- cmpt_qid  out  QID_WIDTH  completion queue ID
- cmpt_pkt_id  out  16  per-source packet number
- busy  out  1  a packet is in flight
- grant_idx  out  $clog2(NUM_SRC)  latched grant

Behaviour:
- Reset: state IDLE; all outputs 0 except m_ctrl_len; rr pointer = 0; beat counter = 0; CMPT FIFO empty; every per-source pkt_id counter = 1.
- Reset mid-packet abandons the partial packet immediately. No tlast and no completion are produced for it.
- FSM has two states, IDLE and XFER.
- IDLE -> XFER when all of the following hold: cfg_en = 1; any s_tvalid = 1; CMPT occupancy plus reservations < CMPT_DEPTH.
  - Winner: first requesting source searching from rr_ptr upward, with wrap.
  - On the transition: latch grant_idx; latch qid = cfg_qid_base + grant_idx; set rr_ptr = grant_idx + 1 (wrap to 0); reserve one CMPT slot.
- XFER, combinational steering:
  - m_tvalid = s_tvalid[grant]; m_tdata = s_tdata[grant]
  - s_tready[grant] = m_tready; all other s_tready = 0
  - m_ctrl_qid = latched qid
- The beat counter increments on each m_tvalid & m_tready. m_tlast = 1 when the counter = PKT_WORDS_LEN-1.
- On the tlast handshake:
  - counter -> 0
  - push {qid, pkt_id[grant]} into the CMPT FIFO and release the reservation
  - pkt_id[grant] += 1, wrapping 0xFFFF -> 0x0000
  - -> IDLE
- One idle cycle (bubble) separates consecutive packets. First-beat latency after IDLE sees a request: 1 cycle.
- In IDLE, m_tvalid = 0, all s_tready = 0 and m_tlast = 0.
- cfg_en deasserted in XFER: the current packet completes normally and no new grant is issued. cfg_qid_base changes take effect only at the next grant.
- Source valid drops mid-packet: the scheduler waits in XFER and never re-arbitrates mid-packet.
- CMPT FIFO:
  - first-word-fall-through; cmpt_tvalid = not empty
  - pop on cmpt_tvalid & cmpt_tready
  - simultaneous push and pop keeps occupancy unchanged
  - a push can never hit a full FIFO because of the reservation; an assertion checks this
- busy = (state == XFER).

Test Plan:
- Single source: NUM_SRC=4, base=0x010, only src2 valid, m_tready=1 -> 8 beats with tlast on beat 8 and ctrl_qid=0x012; one cmpt entry {0x012, pkt_id=1}; next packet carries pkt_id=2.
- Fairness: all 4 sources continuously valid -> grant order 0,1,2,3,0,... with 1 bubble between packets; after 8 packets each source has 2 completions, with pkt_ids 1 and 2.
- Backpressure: m_tready toggles 1-0 every cycle and src1 valid drops for 3 cycles mid-packet -> data order preserved; exactly 8 handshakes; tlast only on the 8th; no grant change.
- CMPT full: cmpt_tready=0 with CMPT_DEPTH=4 -> exactly 4 packets sent, then no grant while sources stay valid; one cmpt pop -> exactly one further packet is granted.
- Enable/config: cfg_en drops on beat 3 -> packet finishes and no new grant follows; change base to 0x7FE with src1 granted -> qid 0x7FF. Base 0x7FF with src1 -> qid wraps to 0x000.
- Reset mid-packet: assert rst on beat 5 -> outputs 0 asynchronously and FIFO empty; after release, a fresh packet from src0 carries pkt_id=1.
